iobus_uart_tx: RTL

//  Memory-mapped UART transmitter that responds to the MCU's IOBUS initiator (IOBUS_ADDR/IOBUS_OUT/IOBUS_WR out, IOBUS_IN back).
//  The CPU writes bytes into a small TX FIFO and polls status. The block serialises the bytes as 8N1 frames on TX.
//  It sits beside the MCU in the top-level wrapper. Its IOBUS_IN is ORed with those of the other peripherals.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/iobus_uart_tx.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the IOBUS UART transmitter:
//   - tx_state_t     : serialiser FSM states
//   - OFS_*          : register offsets from the block's base address
//   - STAT_*         : bit positions inside the STATUS register
//   - eff_div()      : maps a programmed divider to the cycles-per-bit used
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [31:0] OFS_TXDATA = 32'd0;
    localparam logic [31:0] OFS_STATUS = 32'd4;
    localparam logic [31:0] OFS_BAUD   = 32'd8;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

    // A divider of zero would stall the bit timer, so it is treated as one
    // cycle per bit.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. DOUT always shows the head entry
// while the FIFO is not empty; a pop simply advances the read pointer.
// Ports:
//   clk    in          clock, rising edge
//   rst_n  in          asynchronous reset, active-low (empties the FIFO)
//   push   in          write din this cycle (ignored when full unless popping)
//   din    in  WIDTH   write data
//   pop    in          consume the head entry (ignored when empty)
//   dout   out WIDTH   head entry
//   full   out         DEPTH entries held
//   empty  out         no entries held
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit: equal low bits with differing wrap
    // bits means full, fully equal means empty.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when the head leaves in the
    // same cycle, so occupancy never exceeds DEPTH.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        end
    end

    // Storage needs no reset; the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
    end

    assign dout = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/iobus_uart_tx.sv
// ----------------------------------------------------------------------------
// iobus_uart_tx
// Memory-mapped 8N1 UART transmitter on the MCU's IOBUS. The CPU pushes bytes
// into a TX FIFO and polls STATUS; the serialiser sends them LSB first.
// Register window (offsets from BASE_ADDR, full 32-bit decode):
//   +0 TXDATA  W: push [7:0]            R: 0
//   +4 STATUS  R: {28'b0,OVF,BUSY,EMPTY,FULL}   W: clear OVF
//   +8 BAUDDIV R/W [15:0] cycles per bit (0 behaves as 1)
// Ports:
//   clk         in      system clock, rising edge
//   rst_n       in      asynchronous reset, active-low
//   iobus_addr  in  32  byte address
//   iobus_out   in  32  write data
//   iobus_wr    in      write strobe
//   iobus_in    out 32  read data, combinational from iobus_addr (0 if unmapped)
//   tx          out     serial line, registered, idles high
//   tx_irq      out     FIFO empty and serialiser idle
// ----------------------------------------------------------------------------
module iobus_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1100_0100,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] iobus_addr,
    input  logic [31:0] iobus_out,
    input  logic        iobus_wr,
    output logic [31:0] iobus_in,
    output logic        tx,
    output logic        tx_irq
);

    // ---------------- address decode ----------------
    logic sel_txdata;
    logic sel_status;
    logic sel_baud;
    logic wr_txdata;
    logic wr_status;
    logic wr_baud;

    assign sel_txdata = (iobus_addr == BASE_ADDR + OFS_TXDATA);
    assign sel_status = (iobus_addr == BASE_ADDR + OFS_STATUS);
    assign sel_baud   = (iobus_addr == BASE_ADDR + OFS_BAUD);

    assign wr_txdata = iobus_wr && sel_txdata;
    assign wr_status = iobus_wr && sel_status;
    assign wr_baud   = iobus_wr && sel_baud;

    // Only the low half-word of write data is ever stored.
    logic unused_wdata;
    assign unused_wdata = ^iobus_out[31:16];

    // ---------------- state ----------------
    tx_state_t   state_reg;
    logic        tx_reg;
    logic [7:0]  shift_reg;
    logic [15:0] baud_cnt_reg;
    logic [2:0]  bit_idx_reg;
    logic [15:0] baud_div_reg;
    logic        ovf_reg;

    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic        bit_end;
    logic        busy;
    logic [15:0] reload;

    // Reload uses the divider register as it stands at the bit boundary, so
    // a BAUDDIV write never shortens the bit already in progress.
    assign reload  = eff_div(baud_div_reg) - 16'd1;
    assign bit_end = (baud_cnt_reg == 16'd0);
    assign busy    = (state_reg != IDLE);

    // The head is taken when idle, or at the end of a stop bit so that the
    // next start bit follows with no idle gap.
    assign fifo_pop = !fifo_empty &&
                      ((state_reg == IDLE) || ((state_reg == STOP) && bit_end));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_txdata),
        .din   (iobus_out[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_div_reg <= DEFAULT_DIV;
            ovf_reg      <= 1'b0;
        end else begin
            if (wr_baud) baud_div_reg <= iobus_out[15:0];
            // Overflow only when the byte is actually lost: a push into a
            // full FIFO alongside a pop is accepted.
            if (wr_status)
                ovf_reg <= 1'b0;
            else if (wr_txdata && fifo_full && !fifo_pop)
                ovf_reg <= 1'b1;
        end
    end

    // ---------------- serialiser ----------------
    // tx_reg is updated together with each state change, so the line level
    // always corresponds to the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            tx_reg       <= 1'b1;
            shift_reg    <= 8'd0;
            baud_cnt_reg <= 16'd0;
            bit_idx_reg  <= 3'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (fifo_pop) begin
                        shift_reg    <= fifo_dout;
                        baud_cnt_reg <= reload;
                        state_reg    <= START;
                        tx_reg       <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_reg    <= DATA;
                        bit_idx_reg  <= 3'd0;
                        baud_cnt_reg <= reload;
                        tx_reg       <= shift_reg[0];
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt_reg <= reload;
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= STOP;
                            tx_reg    <= 1'b1;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            shift_reg   <= shift_reg >> 1;
                            tx_reg      <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (fifo_pop) begin
                            shift_reg    <= fifo_dout;
                            baud_cnt_reg <= reload;
                            state_reg    <= START;
                            tx_reg       <= 1'b0;
                        end else begin
                            state_reg <= IDLE;
                            tx_reg    <= 1'b1;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg - 16'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tx_reg    <= 1'b1;
                end
            endcase
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        iobus_in = 32'd0;
        if (sel_status) begin
            iobus_in[STAT_FULL]  = fifo_full;
            iobus_in[STAT_EMPTY] = fifo_empty;
            iobus_in[STAT_BUSY]  = busy;
            iobus_in[STAT_OVF]   = ovf_reg;
        end else if (sel_baud) begin
            iobus_in[15:0] = baud_div_reg;
        end
    end

    assign tx     = tx_reg;
    assign tx_irq = fifo_empty && !busy;

endmodule
